// File: rtl/pcileech_pkg.sv
// Shared definitions for the FT601 receive-side word decoder: header field
// layout, channel type codes and the decoder state encoding.
package pcileech_pkg;

  localparam logic [7:0] MAGIC    = 8'h77;
  localparam logic [1:0] TYPE_CFG = 2'b00;
  localparam logic [1:0] TYPE_TLP = 2'b11;

  // Header DW layout: [7:0] magic, [9:8] type, [10] last, rest passed through.
  localparam int HDR_MAGIC_LSB = 0;
  localparam int HDR_MAGIC_W   = 8;
  localparam int HDR_TYPE_LSB  = 8;
  localparam int HDR_TYPE_W    = 2;
  localparam int HDR_LAST_BIT  = 10;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_DATA = 2'd1,
    S_SKIP = 2'd2
  } rx_state_t;

  function automatic logic [7:0] hdr_magic(input logic [31:0] w);
    return w[HDR_MAGIC_LSB +: HDR_MAGIC_W];
  endfunction

  function automatic logic [1:0] hdr_type(input logic [31:0] w);
    return w[HDR_TYPE_LSB +: HDR_TYPE_W];
  endfunction

  function automatic logic hdr_last(input logic [31:0] w);
    return w[HDR_LAST_BIT];
  endfunction

endpackage

// File: rtl/pcileech_out_slot.sv
// Single-entry 64-bit output register for one PCIe controller channel,
// with a synchronous flush that drops the buffered word.
module pcileech_out_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [63:0] push_data,
  output logic        valid,
  output logic [63:0] data,
  input  logic        ready,
  output logic        free
);

  logic        valid_q;
  logic [63:0] data_q;

  // valid/ready: a word transfers on a cycle where valid && ready; data is
  // held stable while valid && !ready. push is only issued while free, so a
  // push in the same cycle as a pop replaces the departing word losslessly.
  assign free  = !valid_q || ready;
  assign valid = valid_q;
  assign data  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (push) begin
      valid_q <= 1'b1;
      data_q  <= push_data;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pcileech_fifo_rx_demux.sv
// Pairs FT601 receive words into {data, header} 64-bit words and routes them
// to the TLP or cfg channel. Diagnostic counters exist only with PCILEECH_RX_DIAG_EN.
module pcileech_fifo_rx_demux
  import pcileech_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             user_clk,
  input  logic             user_reset,
  input  logic             flush,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [63:0]      tlp_data,
  output logic             tlp_valid,
  input  logic             tlp_ready,
  output logic [63:0]      cfg_data,
  output logic             cfg_valid,
  input  logic             cfg_ready,
  output logic [CNT_W-1:0] bad_magic_cnt,
  output logic [CNT_W-1:0] bad_type_cnt,
  output logic [1:0]       dbg_state
);

  rx_state_t   state, state_nxt;
  logic [31:0] hdr_q;
  logic        sel_tlp_q;

  logic        accept;
  logic        good_magic;
  logic        known_type;
  logic        tlp_free, cfg_free, sel_free;
  logic        tlp_push, cfg_push;
  logic [63:0] push_data;

  assign good_magic = (hdr_magic(in_data) == MAGIC);
  assign known_type = (hdr_type(in_data) == TYPE_CFG) || (hdr_type(in_data) == TYPE_TLP);
  assign sel_free   = sel_tlp_q ? tlp_free : cfg_free;

  // Only the pending data DW waits on its channel; headers and skipped words always flow.
  assign in_ready   = !flush && ((state != S_DATA) || sel_free);
  assign accept     = in_valid && in_ready;
  assign push_data  = {in_data, hdr_q};
  assign dbg_state  = state;

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state <= S_HDR;
    end else if (flush) begin
      state <= S_HDR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_HDR: begin
          if (!good_magic)     state_nxt = S_HDR;
          else if (known_type) state_nxt = S_DATA;
          else                 state_nxt = S_SKIP;
        end
        S_DATA:  state_nxt = S_HDR;
        S_SKIP:  state_nxt = S_HDR;
        default: state_nxt = S_HDR;
      endcase
    end
  end

  always_comb begin
    tlp_push = 1'b0;
    cfg_push = 1'b0;
    if (accept && (state == S_DATA)) begin
      tlp_push = sel_tlp_q;
      cfg_push = !sel_tlp_q;
    end
  end

  // A flushed header is simply abandoned; the state returning to S_HDR makes it dead.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      hdr_q     <= '0;
      sel_tlp_q <= 1'b0;
    end else if (accept && (state == S_HDR) && good_magic && known_type) begin
      hdr_q     <= in_data;
      sel_tlp_q <= (hdr_type(in_data) == TYPE_TLP);
    end
  end

  pcileech_out_slot u_tlp_slot (
    .clk       (user_clk),
    .rst       (user_reset),
    .flush     (flush),
    .push      (tlp_push),
    .push_data (push_data),
    .valid     (tlp_valid),
    .data      (tlp_data),
    .ready     (tlp_ready),
    .free      (tlp_free)
  );

  pcileech_out_slot u_cfg_slot (
    .clk       (user_clk),
    .rst       (user_reset),
    .flush     (flush),
    .push      (cfg_push),
    .push_data (push_data),
    .valid     (cfg_valid),
    .data      (cfg_data),
    .ready     (cfg_ready),
    .free      (cfg_free)
  );

`ifdef PCILEECH_RX_DIAG_EN
  logic [CNT_W-1:0] bad_magic_q, bad_type_q;
  logic             hdr_seen;

  assign hdr_seen = accept && (state == S_HDR);

  // Saturating counters: they stick at all-ones and only reset clears them.
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      bad_magic_q <= '0;
      bad_type_q  <= '0;
    end else begin
      if (hdr_seen && !good_magic && !(&bad_magic_q))
        bad_magic_q <= bad_magic_q + CNT_W'(1);
      if (hdr_seen && good_magic && !known_type && !(&bad_type_q))
        bad_type_q <= bad_type_q + CNT_W'(1);
    end
  end

  assign bad_magic_cnt = bad_magic_q;
  assign bad_type_cnt  = bad_type_q;
`else
  assign bad_magic_cnt = '0;
  assign bad_type_cnt  = '0;
`endif

endmodule

// File: tb/tb_pcileech_fifo_rx_demux.sv
// Bench for pcileech_fifo_rx_demux: table vectors, hand-written corner
// sequences and a randomized stream checked against a stream-parsing model.
module tb_pcileech_fifo_rx_demux;
  import pcileech_pkg::*;

  localparam int CNT_W = 4;
  localparam int LIMIT = 200;

  logic             clk = 1'b0;
  logic             user_reset = 1'b1;
  logic             flush = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [63:0]      tlp_data, cfg_data;
  logic             tlp_valid, cfg_valid;
  logic             tlp_ready, cfg_ready;
  logic [CNT_W-1:0] bad_magic_cnt, bad_type_cnt;
  logic [1:0]       dbg_state;

  logic tlp_force = 1'b1, cfg_force = 1'b1, rand_en = 1'b0;
  logic rnd_tlp = 1'b1, rnd_cfg = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [63:0] got_tlp_q[$], got_cfg_q[$];
  logic [31:0] acc_q[$];
  logic [63:0] exp_tlp_q[$], exp_cfg_q[$];
  logic        stab_en = 1'b0;
  int          stab_bad = 0;
  logic        p_tlp_v = 1'b0, p_tlp_r = 1'b0, p_cfg_v = 1'b0, p_cfg_r = 1'b0;
  logic [63:0] p_tlp_d = '0, p_cfg_d = '0;

  pcileech_fifo_rx_demux #(.CNT_W(CNT_W)) dut (
    .user_clk      (clk),
    .user_reset    (user_reset),
    .flush         (flush),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .tlp_data      (tlp_data),
    .tlp_valid     (tlp_valid),
    .tlp_ready     (tlp_ready),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .bad_magic_cnt (bad_magic_cnt),
    .bad_type_cnt  (bad_type_cnt),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_tlp = 1'($urandom_range(0, 1));
    rnd_cfg = 1'($urandom_range(0, 1));
  end

  always_comb begin
    tlp_ready = rand_en ? rnd_tlp : tlp_force;
    cfg_ready = rand_en ? rnd_cfg : cfg_force;
  end

  task automatic do_reset();
    user_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    user_reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (tlp_valid && tlp_ready) got_tlp_q.push_back(tlp_data);
    if (cfg_valid && cfg_ready) got_cfg_q.push_back(cfg_data);
    if (in_valid && in_ready) acc_q.push_back(in_data);
    if (stab_en) begin
      if (p_tlp_v && !p_tlp_r && (!tlp_valid || tlp_data !== p_tlp_d)) stab_bad++;
      if (p_cfg_v && !p_cfg_r && (!cfg_valid || cfg_data !== p_cfg_d)) stab_bad++;
    end
    p_tlp_v = tlp_valid; p_tlp_r = tlp_ready; p_tlp_d = tlp_data;
    p_cfg_v = cfg_valid; p_cfg_r = cfg_ready; p_cfg_d = cfg_data;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] cnt_exp(input int n);
`ifdef PCILEECH_RX_DIAG_EN
    return (n > 15) ? 64'd15 : 64'(n);
`else
    return 64'd0 + 64'(n * 0);
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] hdr;
    logic [31:0] dat;
    logic        is_tlp;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  // ---------------- reference model ----------------
  task automatic model_stream(input int start, output int bm, output int bt);
    int i = start;
    logic [31:0] w;
    bm = 0;
    bt = 0;
    while (i < acc_q.size()) begin
      w = acc_q[i];
      if (w[7:0] != 8'h77) begin
        bm++;
        i += 1;
      end else if (w[9:8] == 2'b01 || w[9:8] == 2'b10) begin
        bt++;
        i += 2;
      end else if (i + 1 < acc_q.size()) begin
        if (w[9:8] == 2'b11) exp_tlp_q.push_back({acc_q[i+1], w});
        else                 exp_cfg_q.push_back({acc_q[i+1], w});
        i += 2;
      end else begin
        i += 1;
      end
    end
  endtask

  initial begin
    int t0, c0, a0, bm, bt;
    logic [31:0] r, w;

    vecs[0] = '{32'h0000_0777, 32'hDEAD_BEEF, 1'b1, 64'hDEADBEEF_00000777};
    vecs[1] = '{32'h0000_0077, 32'h0000_0004, 1'b0, 64'h00000004_00000077};
    vecs[2] = '{32'hABCD_0B77, 32'h0000_0001, 1'b1, 64'h00000001_ABCD0B77};
    vecs[3] = '{32'hFFFF_F877, 32'h8000_0000, 1'b0, 64'h80000000_FFFFF877};
    vecs[4] = '{32'h1234_0377, 32'hFFFF_FFFF, 1'b1, 64'hFFFFFFFF_12340377};

    do_reset();
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_tlp_valid", 64'(tlp_valid), 64'd0);
    check("rst_cfg_valid", 64'(cfg_valid), 64'd0);
    check("rst_tlp_data",  tlp_data, 64'd0);
    check("rst_cfg_data",  cfg_data, 64'd0);
    check("rst_bad_magic", 64'(bad_magic_cnt), 64'd0);
    check("rst_bad_type",  64'(bad_type_cnt), 64'd0);
    check("rst_state",     64'(dbg_state), 64'(S_HDR));
    @(posedge clk); #1;

    // table-driven pairs, output sampled the cycle after the data DW
    foreach (vecs[k]) begin
      send_word(vecs[k].hdr);
      send_word(vecs[k].dat);
      @(negedge clk);
      check($sformatf("vec%0d_tlp_valid", k), 64'(tlp_valid), 64'(vecs[k].is_tlp));
      check($sformatf("vec%0d_cfg_valid", k), 64'(cfg_valid), 64'(!vecs[k].is_tlp));
      check($sformatf("vec%0d_data", k), vecs[k].is_tlp ? tlp_data : cfg_data, vecs[k].exp);
      @(posedge clk); #1;
    end

    // bad magic then a good tlp pair
    do_reset();
    t0 = got_tlp_q.size(); c0 = got_cfg_q.size();
    send_word(32'h1234_5678);
    send_word(32'h0000_0777);
    send_word(32'hCAFE_F00D);
    repeat (3) @(posedge clk); #1;
    check("bm_cnt", 64'(bad_magic_cnt), cnt_exp(1));
    check("bm_tlp_count", 64'(got_tlp_q.size() - t0), 64'd1);
    check("bm_tlp_word", got_tlp_q[got_tlp_q.size()-1], 64'hCAFEF00D_00000777);
    check("bm_cfg_count", 64'(got_cfg_q.size() - c0), 64'd0);

    // reserved type: next word is skipped, not parsed as a header
    do_reset();
    t0 = got_tlp_q.size(); c0 = got_cfg_q.size();
    send_word(32'h0000_0177);
    send_word(32'h0000_0777);
    send_word(32'h0000_0077);
    send_word(32'h0000_0004);
    repeat (3) @(posedge clk); #1;
    check("bt_cnt", 64'(bad_type_cnt), cnt_exp(1));
    check("bt_magic_cnt", 64'(bad_magic_cnt), cnt_exp(0));
    check("bt_cfg_count", 64'(got_cfg_q.size() - c0), 64'd1);
    check("bt_cfg_word", got_cfg_q[got_cfg_q.size()-1], 64'h00000004_00000077);
    check("bt_tlp_count", 64'(got_tlp_q.size() - t0), 64'd0);

    // stalled cfg channel: tlp still flows, second cfg data DW waits
    do_reset();
    t0 = got_tlp_q.size(); c0 = got_cfg_q.size();
    cfg_force = 1'b0;
    send_word(32'h0000_0077);
    send_word(32'h0000_0011);
    send_word(32'h0000_0777);
    send_word(32'h0000_0022);
    send_word(32'h0000_0077);
    repeat (2) @(posedge clk); #1;
    check("stall_tlp_count", 64'(got_tlp_q.size() - t0), 64'd1);
    check("stall_tlp_word", got_tlp_q[got_tlp_q.size()-1], 64'h00000022_00000777);
    in_data = 32'h0000_0033;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready_low", 64'(in_ready), 64'd0);
    end
    check("stall_cfg_held", cfg_data, 64'h00000011_00000077);
    @(posedge clk); #1;
    cfg_force = 1'b1;
    @(negedge clk);
    check("stall_in_ready_high", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("stall_cfg_count", 64'(got_cfg_q.size() - c0), 64'd2);
    check("stall_cfg_last", got_cfg_q[got_cfg_q.size()-1], 64'h00000033_00000077);

    // flush between header and data
    do_reset();
    t0 = got_tlp_q.size(); c0 = got_cfg_q.size();
    send_word(32'h0000_0777);
    flush = 1'b1;
    in_data = 32'hBAD0_BAD0;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_state", 64'(dbg_state), 64'(S_HDR));
    @(posedge clk); #1;
    send_word(32'h0000_0777);
    send_word(32'h600D_F00D);
    repeat (3) @(posedge clk); #1;
    check("flush_tlp_count", 64'(got_tlp_q.size() - t0), 64'd1);
    check("flush_tlp_word", got_tlp_q[got_tlp_q.size()-1], 64'h600DF00D_00000777);
    check("flush_cfg_count", 64'(got_cfg_q.size() - c0), 64'd0);

    // asynchronous reset mid-pair
    t0 = got_tlp_q.size(); c0 = got_cfg_q.size();
    send_word(32'h0000_0777);
    #2 user_reset = 1'b1;
    #4 user_reset = 1'b0;
    @(posedge clk); #1;
    send_word(32'h0000_0077);
    send_word(32'h0000_0005);
    repeat (3) @(posedge clk); #1;
    check("arst_tlp_count", 64'(got_tlp_q.size() - t0), 64'd0);
    check("arst_cfg_count", 64'(got_cfg_q.size() - c0), 64'd1);
    check("arst_cfg_word", got_cfg_q[got_cfg_q.size()-1], 64'h00000005_00000077);

    // counter saturation
    for (int i = 0; i < 20; i++) send_word(32'h0000_0000);
    @(negedge clk);
    check("sat_bad_magic", 64'(bad_magic_cnt), cnt_exp(20));

    // randomized stream against the parsing model
    do_reset();
    a0 = acc_q.size(); t0 = got_tlp_q.size(); c0 = got_cfg_q.size();
    rand_en = 1'b1;
    stab_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: w = {r[31:10], ($urandom_range(0, 1) == 1) ? TYPE_TLP : TYPE_CFG, 8'h77};
        8:                w = {r[31:10], ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, 8'h77};
        default:          w = r;
      endcase
      send_word(w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_en = 1'b0;
    repeat (10) @(posedge clk); #1;
    stab_en = 1'b0;
    check("rand_hold_stable", 64'(stab_bad), 64'd0);

    model_stream(a0, bm, bt);
    check("rand_bad_magic", 64'(bad_magic_cnt), cnt_exp(bm));
    check("rand_bad_type", 64'(bad_type_cnt), cnt_exp(bt));
    check("rand_tlp_count", 64'(got_tlp_q.size() - t0), 64'(exp_tlp_q.size()));
    check("rand_cfg_count", 64'(got_cfg_q.size() - c0), 64'(exp_cfg_q.size()));
    for (int i = 0; i < exp_tlp_q.size() && t0 + i < got_tlp_q.size(); i++)
      check($sformatf("rand_tlp_%0d", i), got_tlp_q[t0+i], exp_tlp_q[i]);
    for (int i = 0; i < exp_cfg_q.size() && c0 + i < got_cfg_q.size(); i++)
      check($sformatf("rand_cfg_%0d", i), got_cfg_q[c0+i], exp_cfg_q[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
